enigma_stream_decryptor: RTL and testbench
==========================================

ENIGMA_STREAM_DECRYPTOR -- requirements
Module: enigma_stream_decryptor

Interface
REQ-001 SHALL have parameter STEP, default 1, meaning rotor increment per accepted letter (legal 1..25).
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port load_key  input  1  load rotor start position this cycle.
REQ-005 SHALL have port start_key  input  5  rotor start position, 0..25.
REQ-006 SHALL have port in_valid  input  1  ciphertext character present.
REQ-007 SHALL have port in_ready  output  1  block accepts in_char this cycle.
REQ-008 SHALL have port in_char  input  7  ciphertext code; 0..25 = A..Z, 26..127 = non-letter.
REQ-009 SHALL have port out_valid  output  1  out_char holds a decrypted character.
REQ-010 SHALL have port out_ready  input  1  downstream consumes out_char this cycle.
REQ-011 SHALL have port out_char  output  7  decrypted character code.
REQ-012 SHALL have port rotor_pos  output  5  current rotor position, 0..25.

Function
REQ-013 SHALL implement FSM states UNKEYED, RUN; reset enters UNKEYED.
REQ-014 UNKEYED: in_ready=0; load_key=1 -> RUN with rotor_pos=start_key.
REQ-015 RUN: load_key=1 -> rotor_pos=start_key, stay RUN, output register contents retained.
REQ-016 start_key values 26..31 SHALL load as 0.
REQ-017 in_ready SHALL be 1 iff state=RUN and load_key=0 and (out_valid=0 or out_ready=1).
REQ-018 Transfer in: in_valid&in_ready; transfer out: out_valid&out_ready; both in same cycle SHALL be legal (full throughput, one char/cycle).
REQ-019 On transfer in of letter c with rotor r: out_char <= (c - r) mod 26, computed as c-r, adding 26 when c<r.
REQ-020 On transfer in of non-letter: out_char <= in_char unchanged, rotor not stepped.
REQ-021 On transfer in of letter: rotor_pos <= (rotor_pos + STEP) mod 26 (wrap 25+1 -> 0).
REQ-022 Latency SHALL be 1 cycle: out_valid rises the cycle after transfer in.
REQ-023 out_valid SHALL clear after transfer out with no same-cycle transfer in; out_char SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 Decryption of a stream SHALL exactly invert an encryptor using (c + r) mod 26 with identical start_key, STEP and stepping rule.

Reset
REQ-025 reset SHALL take priority over all inputs, including load_key.
REQ-026 After reset: state=UNKEYED, rotor_pos=0, out_valid=0, out_char=0, in_ready=0.
REQ-027 reset asserted mid-stream SHALL discard any held output character.

Configuration
REQ-028 Macro DOUBLE_ROTOR_EN SHALL, when defined, add a second rotor and port rotor2_pos output 5.
REQ-029 With DOUBLE_ROTOR_EN: rotor2 increments mod 26 in the cycle rotor1 wraps past 25; load_key and reset set rotor2 to 0; effective shift r = (rotor_pos + rotor2_pos) mod 26.
REQ-030 Without DOUBLE_ROTOR_EN: single rotor only, no rotor2_pos port, r = rotor_pos.

Verification
REQ-031 Reset then in_valid=1 with no key -> in_ready=0, out_valid stays 0.
REQ-032 Key 3, STEP=1, stream codes 3,4,5 with out_ready=1 -> out_char 0,0,0 on consecutive cycles, rotor_pos ends 6.
REQ-033 Key 25, letter 0 -> out_char 1 (wrap-add), rotor_pos -> 0; next letter 0 -> out_char 0.
REQ-034 Key 2, chars 0, 30, 0 -> out_char 24, 30, 23; rotor_pos 2->3->3->4.
REQ-035 out_ready=0 for 5 cycles after first output -> out_char/out_valid stable, in_ready=0; release -> stream resumes with no loss or duplication.
REQ-036 DOUBLE_ROTOR_EN, key 25, two letters 5,5 -> out_char 6, then 4 (rotor2=1); reset mid-stream -> all outputs per REQ-026.

Source files
------------

// File: rtl/enigma_stream_decryptor.sv
// enigma_stream_decryptor
//   Single-rotor Caesar-style stream decryptor with a ready/valid handshake
//   on both sides. Each accepted letter (codes 0..25) is shifted down by the
//   current rotor position mod 26 and then steps the rotor by STEP. Codes
//   26..127 pass through unchanged and leave the rotor where it is. There is
//   one output register, so the latency is one cycle and a new character can
//   be accepted in the same cycle as the held one is consumed.
//
// Optional build macro: DOUBLE_ROTOR_EN
//   Adds a second rotor. It steps whenever rotor 1 wraps past 25. The
//   effective shift is (rotor_pos + rotor2_pos) mod 26.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset; overrides every input
//   load_key   in   load start_key into the rotor (rotor 2 is cleared)
//   start_key  in   5  rotor start position; values 26..31 load as 0
//   in_valid   in   ciphertext character present
//   in_ready   out  character accepted this cycle
//   in_char    in   7  ciphertext code
//   out_valid  out  out_char holds a decrypted character
//   out_ready  in   downstream consumes out_char this cycle
//   out_char   out  7  decrypted code
//   rotor_pos  out  5  current rotor position
//   rotor2_pos out  5  second rotor position (DOUBLE_ROTOR_EN only)
module enigma_stream_decryptor #(
    parameter int STEP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_key,
    input  logic [4:0] start_key,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] in_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] out_char,
    output logic [4:0] rotor_pos
`ifdef DOUBLE_ROTOR_EN
    ,
    output logic [4:0] rotor2_pos
`endif
);

    localparam logic [5:0] STEP6 = 6'(STEP);

    typedef enum logic {UNKEYED, RUN} state_t;

    state_t     state_q, state_d;
    logic [4:0] rot_q, rot_d;
    logic       vld_q, vld_d;
    logic [6:0] char_q, char_d;
`ifdef DOUBLE_ROTOR_EN
    logic [4:0] rot2_q, rot2_d;
`endif

    logic       is_letter;
    logic       xfer_in;
    logic       xfer_out;
    logic [4:0] shift;
    logic [4:0] key_val;
    logic [5:0] rot_sum;

    // Reduce a sum of two values in 0..25 (so at most 50) into 0..25.
    function automatic logic [4:0] mod26(input logic [5:0] s);
        return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
    endfunction

    // (c - r) mod 26 for c, r in 0..25, without a signed intermediate.
    function automatic logic [4:0] sub_mod26(input logic [4:0] c, input logic [4:0] r);
        return (c < r) ? 5'(6'(c) + 6'd26 - 6'(r)) : (c - r);
    endfunction

    function automatic logic [4:0] sanitize_key(input logic [4:0] k);
        return (k > 5'd25) ? 5'd0 : k;
    endfunction

    assign is_letter = (in_char < 7'd26);
    assign key_val   = sanitize_key(start_key);
    assign rot_sum   = {1'b0, rot_q} + STEP6;
`ifdef DOUBLE_ROTOR_EN
    assign shift     = mod26({1'b0, rot_q} + {1'b0, rot2_q});
`else
    assign shift     = rot_q;
`endif

    // A key load blocks input for that cycle so the new key never mixes with
    // a character shifted under the old one.
    assign in_ready = (state_q == RUN) && !load_key && (!vld_q || out_ready);
    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = vld_q && out_ready;

    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        vld_d   = vld_q;
        char_d  = char_q;
`ifdef DOUBLE_ROTOR_EN
        rot2_d  = rot2_q;
`endif
        case (state_q)
            UNKEYED: begin
                if (load_key) begin
                    state_d = RUN;
                    rot_d   = key_val;
`ifdef DOUBLE_ROTOR_EN
                    rot2_d  = 5'd0;
`endif
                end
            end
            RUN: begin
                if (load_key) begin
                    rot_d  = key_val;
`ifdef DOUBLE_ROTOR_EN
                    rot2_d = 5'd0;
`endif
                end
                // xfer_in is never true during a key load (in_ready is low).
                if (xfer_in) begin
                    vld_d = 1'b1;
                    if (is_letter) begin
                        char_d = {2'b00, sub_mod26(in_char[4:0], shift)};
                        rot_d  = mod26(rot_sum);
`ifdef DOUBLE_ROTOR_EN
                        if (rot_sum >= 6'd26) begin
                            rot2_d = mod26({1'b0, rot2_q} + 6'd1);
                        end
`endif
                    end else begin
                        char_d = in_char;
                    end
                end else if (xfer_out) begin
                    vld_d = 1'b0;
                end
            end
            default: state_d = UNKEYED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNKEYED;
            rot_q   <= 5'd0;
            vld_q   <= 1'b0;
            char_q  <= 7'd0;
`ifdef DOUBLE_ROTOR_EN
            rot2_q  <= 5'd0;
`endif
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            vld_q   <= vld_d;
            char_q  <= char_d;
`ifdef DOUBLE_ROTOR_EN
            rot2_q  <= rot2_d;
`endif
        end
    end

    assign out_valid  = vld_q;
    assign out_char   = char_q;
    assign rotor_pos  = rot_q;
`ifdef DOUBLE_ROTOR_EN
    assign rotor2_pos = rot2_q;
`endif

endmodule

// File: tb/tb_enigma_stream_decryptor.sv
// Testbench for enigma_stream_decryptor. The scoreboard queue receives the
// expected plaintext whenever a character is accepted and is popped whenever
// the DUT hands a character downstream.
module tb_enigma_stream_decryptor;

    localparam int STEP = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_key = 1'b0;
    logic [4:0] start_key = 5'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] in_char = 7'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [6:0] out_char;
    logic [4:0] rotor_pos;
`ifdef DOUBLE_ROTOR_EN
    logic [4:0] rotor2_pos;
`endif

    int checks = 0;
    int failures = 0;
    int last_ncyc = 0;

    logic [6:0] sbq[$];
    logic [6:0] obs_act[$];
    logic [6:0] obs_exp[$];
    logic [6:0] stim_ch[$];
    logic [6:0] stim_ex[$];

    enigma_stream_decryptor #(.STEP(STEP)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_key  (load_key),
        .start_key (start_key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .rotor_pos (rotor_pos)
`ifdef DOUBLE_ROTOR_EN
        ,
        .rotor2_pos(rotor2_pos)
`endif
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1; load_key = 1'b0; in_valid = 1'b0; in_char = 7'd0;
        out_ready = 1'b1; start_key = 5'd0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        sbq.delete();
    endtask

    task automatic do_key(input logic [4:0] k);
        load_key = 1'b1; start_key = k;
        @(posedge clk); @(negedge clk);
        load_key = 1'b0;
    endtask

    // One clock with scoreboard bookkeeping; inputs are already driven.
    task automatic step_cycle(input logic [6:0] exp_in, output bit xin, output bit xout,
                              output logic [6:0] act, output logic [6:0] expv);
        #1;
        xin  = in_valid && in_ready;
        xout = out_valid && out_ready;
        act  = out_char;
        expv = 7'd0;
        if (xout) begin
            if (sbq.size() > 0) expv = sbq.pop_front();
            else expv = 'x;
        end
        if (xin) sbq.push_back(exp_in);
        @(posedge clk); @(negedge clk);
    endtask

    // Feeds stim_ch (expected stim_ex) until n_out characters leave the DUT.
    task automatic drive_stream(input int n_out, input int max_cyc, input bit rand_ready,
                                output bit timeout);
        int i = 0;
        int ncyc = 0;
        bit xin, xout;
        logic [6:0] a, e, ex;
        obs_act.delete(); obs_exp.delete();
        while (obs_act.size() < n_out && ncyc < max_cyc) begin
            ex = 7'd0;
            in_valid = 1'b0;
            in_char = 7'd0;
            if (i < stim_ch.size()) begin
                in_valid = 1'b1; in_char = stim_ch[i]; ex = stim_ex[i];
            end
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            step_cycle(ex, xin, xout, a, e);
            if (xin) i++;
            if (xout) begin obs_act.push_back(a); obs_exp.push_back(e); end
            ncyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        last_ncyc = ncyc;
        timeout = (obs_act.size() < n_out);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0d want=0", out_valid); end
        checks++; if (out_char !== 7'd0) begin failures++; $display("FAIL rst_out_char got=%0d want=0", out_char); end
        checks++; if (rotor_pos !== 5'd0) begin failures++; $display("FAIL rst_rotor got=%0d want=0", rotor_pos); end
        in_valid = 1'b1; in_char = 7'd4;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL unkeyed_in_ready got=%0d want=0", in_ready); end
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL unkeyed_out_valid got=%0d want=0", out_valid); end
            @(posedge clk); @(negedge clk);
        end
        // reset wins over a simultaneous key load
        reset = 1'b1; load_key = 1'b1; start_key = 5'd9;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; load_key = 1'b0;
        #1;
        checks++; if (rotor_pos !== 5'd0) begin failures++; $display("FAIL rst_prio_rotor got=%0d want=0", rotor_pos); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_prio_in_ready got=%0d want=0", in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to;
        do_reset(); do_key(5'd3);
        checks++; if (rotor_pos !== 5'd3) begin failures++; $display("FAIL basic_key got=%0d want=3", rotor_pos); end
        stim_ch = '{7'd3, 7'd4, 7'd5}; stim_ex = '{7'd0, 7'd0, 7'd0};
        drive_stream(3, 20, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout got=%0d want=3 outputs", obs_act.size()); end
        foreach (obs_act[k]) begin
            checks++; if (obs_act[k] !== obs_exp[k]) begin failures++; $display("FAIL basic_char[%0d] got=%0d want=%0d", k, obs_act[k], obs_exp[k]); end
        end
        checks++; if (last_ncyc !== 4) begin failures++; $display("FAIL basic_throughput got=%0d cycles want=4", last_ncyc); end
        checks++; if (rotor_pos !== 5'd6) begin failures++; $display("FAIL basic_rotor_end got=%0d want=6", rotor_pos); end
    endtask

    task automatic test_wrap();
        bit to;
        logic [6:0] second;
`ifdef DOUBLE_ROTOR_EN
        second = 7'd25;
`else
        second = 7'd0;
`endif
        do_reset(); do_key(5'd25);
        stim_ch = '{7'd0}; stim_ex = '{7'd1};
        drive_stream(1, 10, 1'b0, to);
        checks++; if (to || obs_act[0] !== obs_exp[0]) begin failures++; $display("FAIL wrap_char0 got=%0d want=1", out_char); end
        checks++; if (rotor_pos !== 5'd0) begin failures++; $display("FAIL wrap_rotor got=%0d want=0", rotor_pos); end
        stim_ch = '{7'd0}; stim_ex = '{second};
        drive_stream(1, 10, 1'b0, to);
        checks++; if (to || obs_act[0] !== obs_exp[0]) begin failures++; $display("FAIL wrap_char1 got=%0d want=%0d", out_char, second); end
        checks++; if (rotor_pos !== 5'd1) begin failures++; $display("FAIL wrap_rotor1 got=%0d want=1", rotor_pos); end
    endtask

    task automatic test_nonletter();
        bit to;
        logic [6:0] ch_t[3];
        logic [6:0] ex_t[3];
        logic [4:0] rot_t[3];
        ch_t = '{7'd0, 7'd30, 7'd0};
        ex_t = '{7'd24, 7'd30, 7'd23};
        rot_t = '{5'd3, 5'd3, 5'd4};
        do_reset(); do_key(5'd2);
        for (int k = 0; k < 3; k++) begin
            stim_ch = '{ch_t[k]}; stim_ex = '{ex_t[k]};
            drive_stream(1, 10, 1'b0, to);
            checks++; if (to || obs_act[0] !== obs_exp[0]) begin failures++; $display("FAIL nonletter_char[%0d] got=%0d want=%0d", k, out_char, ex_t[k]); end
            checks++; if (rotor_pos !== rot_t[k]) begin failures++; $display("FAIL nonletter_rotor[%0d] got=%0d want=%0d", k, rotor_pos, rot_t[k]); end
        end
    endtask

    task automatic test_rekey();
        bit to, xin, xout;
        logic [6:0] a, e;
        do_reset(); do_key(5'd30);
        checks++; if (rotor_pos !== 5'd0) begin failures++; $display("FAIL key30_rotor got=%0d want=0", rotor_pos); end
        out_ready = 1'b0; in_valid = 1'b1; in_char = 7'd7;
        step_cycle(7'd7, xin, xout, a, e);
        checks++; if (!xin) begin failures++; $display("FAIL rekey_accept got=%0d want=1", xin); end
        load_key = 1'b1; start_key = 5'd10; in_char = 7'd9;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rekey_in_ready got=%0d want=0", in_ready); end
        @(posedge clk); @(negedge clk);
        load_key = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_char !== 7'd7) begin failures++; $display("FAIL rekey_hold got=%0d/%0d want=1/7", out_valid, out_char); end
        checks++; if (rotor_pos !== 5'd10) begin failures++; $display("FAIL rekey_rotor got=%0d want=10", rotor_pos); end
        stim_ch = '{7'd12}; stim_ex = '{7'd2};
        drive_stream(2, 10, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL rekey_timeout got=%0d want=2 outputs", obs_act.size()); end
        foreach (obs_act[k]) begin
            checks++; if (obs_act[k] !== obs_exp[k]) begin failures++; $display("FAIL rekey_char[%0d] got=%0d want=%0d", k, obs_act[k], obs_exp[k]); end
        end
    endtask

    task automatic test_backpressure();
        bit to, xin, xout;
        logic [6:0] a, e;
        do_reset(); do_key(5'd0);
        in_valid = 1'b1; in_char = 7'd10;
        step_cycle(7'd10, xin, xout, a, e);
        checks++; if (!xin) begin failures++; $display("FAIL bp_accept got=%0d want=1", xin); end
        out_ready = 1'b0; in_char = 7'd20;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_char !== 7'd10) begin failures++; $display("FAIL bp_hold[%0d] got=%0d/%0d want=1/10", k, out_valid, out_char); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%0d want=0", k, in_ready); end
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        stim_ch = '{7'd20, 7'd5}; stim_ex = '{7'd19, 7'd3};
        drive_stream(3, 20, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL bp_timeout got=%0d want=3 outputs", obs_act.size()); end
        foreach (obs_act[k]) begin
            checks++; if (obs_act[k] !== obs_exp[k]) begin failures++; $display("FAIL bp_char[%0d] got=%0d want=%0d", k, obs_act[k], obs_exp[k]); end
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup[%0d] got=%0d want=0", k, out_valid); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int er, er2;
        logic [6:0] p, c;
        do_reset();
        er = $urandom_range(0, 25); er2 = 0;
        do_key(5'(er));
        stim_ch.delete(); stim_ex.delete();
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 5) == 0) p = 7'($urandom_range(26, 127));
            else p = 7'($urandom_range(0, 25));
            if (p < 7'd26) begin
                c = 7'((int'(p) + (er + er2) % 26) % 26);
                er = er + STEP;
                if (er >= 26) begin
                    er = er - 26;
`ifdef DOUBLE_ROTOR_EN
                    er2 = (er2 + 1) % 26;
`endif
                end
            end else begin
                c = p;
            end
            stim_ch.push_back(c); stim_ex.push_back(p);
        end
        drive_stream(40, 400, 1'b1, to);
        checks++; if (to) begin failures++; $display("FAIL b2b_timeout got=%0d want=40 outputs", obs_act.size()); end
        foreach (obs_act[k]) begin
            checks++; if (obs_act[k] !== obs_exp[k]) begin failures++; $display("FAIL b2b_char[%0d] got=%0d want=%0d", k, obs_act[k], obs_exp[k]); end
        end
        checks++; if (rotor_pos !== 5'(er)) begin failures++; $display("FAIL b2b_rotor got=%0d want=%0d", rotor_pos, er); end
    endtask

    task automatic test_mid_reset();
        bit xin, xout;
        logic [6:0] a, e;
        do_reset(); do_key(5'd4);
        out_ready = 1'b0; in_valid = 1'b1; in_char = 7'd9;
        step_cycle(7'd5, xin, xout, a, e);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%0d want=1", out_valid); end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; in_valid = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_char !== 7'd0) begin failures++; $display("FAIL midrst_out got=%0d/%0d want=0/0", out_valid, out_char); end
        checks++; if (rotor_pos !== 5'd0 || in_ready !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got=%0d/%0d want=0/0", rotor_pos, in_ready); end
`ifdef DOUBLE_ROTOR_EN
        checks++; if (rotor2_pos !== 5'd0) begin failures++; $display("FAIL midrst_rotor2 got=%0d want=0", rotor2_pos); end
`endif
        in_valid = 1'b0; out_ready = 1'b1;
        sbq.delete();
        @(negedge clk);
    endtask

`ifdef DOUBLE_ROTOR_EN
    task automatic test_double_rotor();
        bit to;
        do_reset(); do_key(5'd25);
        stim_ch = '{7'd5, 7'd5}; stim_ex = '{7'd6, 7'd4};
        drive_stream(2, 10, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL dr_timeout got=%0d want=2 outputs", obs_act.size()); end
        foreach (obs_act[k]) begin
            checks++; if (obs_act[k] !== obs_exp[k]) begin failures++; $display("FAIL dr_char[%0d] got=%0d want=%0d", k, obs_act[k], obs_exp[k]); end
        end
        checks++; if (rotor2_pos !== 5'd1) begin failures++; $display("FAIL dr_rotor2 got=%0d want=1", rotor2_pos); end
        do_key(5'd3);
        checks++; if (rotor2_pos !== 5'd0 || rotor_pos !== 5'd3) begin failures++; $display("FAIL dr_rekey got=%0d/%0d want=3/0", rotor_pos, rotor2_pos); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_nonletter();
        test_rekey();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
`ifdef DOUBLE_ROTOR_EN
        test_double_rotor();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
